// File: rtl/seg7_capture_bcd_pkg.sv
// Shared 7-segment constants and decode result type.
// Patterns are written as seg_n[0:6] (a..g), active-low.
package seg7_capture_bcd_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_NONE = 4'hF;

  typedef struct packed {
    logic [3:0] bcd;
    logic       blank;
    logic       err;
  } seg7_dec_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment pattern to BCD/blank/err decode.
// SEG7_CAPTURE_ERR_EN: flag illegal patterns as err, else as blank.
module seg7_pattern_decode
  import seg7_capture_bcd_pkg::*;
(
  input  logic [6:0] pat,
  output seg7_dec_t  dec
);

  always_comb begin
    dec = '{bcd: BCD_NONE, blank: 1'b0, err: 1'b0};
    case (pat)
      SEG_0:     dec.bcd = 4'd0;
      SEG_1:     dec.bcd = 4'd1;
      SEG_2:     dec.bcd = 4'd2;
      SEG_3:     dec.bcd = 4'd3;
      SEG_4:     dec.bcd = 4'd4;
      SEG_5:     dec.bcd = 4'd5;
      SEG_6:     dec.bcd = 4'd6;
      SEG_7:     dec.bcd = 4'd7;
      SEG_8:     dec.bcd = 4'd8;
      SEG_9:     dec.bcd = 4'd9;
      SEG_BLANK: dec.blank = 1'b1;
      default: begin
`ifdef SEG7_CAPTURE_ERR_EN
        dec.err = 1'b1;
`else
        dec.blank = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/seg7_capture_bcd.sv
// Recovers BCD digits from a multiplexed active-low 7-seg bus.
// SEG7_CAPTURE_ERR_EN enables err reporting for illegal patterns.
module seg7_capture_bcd
  import seg7_capture_bcd_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [0:6]            seg_n,
  input  logic [DIGITS-1:0]     dig_en_n,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic [DIGITS-1:0]     err,
  output logic                  valid,
  output logic                  upd
);

  localparam logic [3:0] SAT = 4'(STABLE_CNT);

  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] dig_q, dig_d;
  logic [6:0]        cand_q [DIGITS];
  logic [6:0]        cand_d [DIGITS];
  logic [3:0]        cnt_q  [DIGITS];
  logic [3:0]        cnt_d  [DIGITS];
  seg7_dec_t         res_q  [DIGITS];
  seg7_dec_t         res_d  [DIGITS];
  logic [DIGITS-1:0] acc_q, acc_d;
  logic              valid_q, valid_d;
  logic              upd_q, upd_d;

  logic [DIGITS-1:0] strb;
  logic              one_hot;
  logic              hit;
  seg7_dec_t         dec;

  seg7_pattern_decode u_dec (
    .pat (seg_q),
    .dec (dec)
  );

  always_comb begin
    seg_d   = seg_n;
    dig_d   = dig_en_n;
    strb    = ~dig_q;
    one_hot = (strb != '0) &&
              ((strb & (strb - DIGITS'(1))) == '0);
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    acc_d   = acc_q;
    upd_d   = 1'b0;
    hit     = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      hit = 1'b0;
      if (one_hot && strb[d]) begin
        if (seg_q == cand_q[d]) begin
          if (cnt_q[d] != SAT) begin
            cnt_d[d] = cnt_q[d] + 4'd1;
            hit      = (cnt_d[d] == SAT);
          end
        end else begin
          cand_d[d] = seg_q;
          cnt_d[d]  = 4'd1;
          hit       = (SAT == 4'd1);
        end
      end
      if (hit) begin
        res_d[d] = dec;
        acc_d[d] = 1'b1;
        if (dec != res_q[d]) upd_d = 1'b1;
      end
    end
    valid_d = &acc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q   <= SEG_BLANK;
      dig_q   <= '1;
      for (int d = 0; d < DIGITS; d++) begin
        cand_q[d] <= 7'h7F;
        cnt_q[d]  <= 4'd0;
        res_q[d]  <= '{bcd: BCD_NONE,
                       blank: 1'b1,
                       err: 1'b0};
      end
      acc_q   <= '0;
      valid_q <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
      upd_q   <= upd_d;
    end
  end

  always_comb begin
    for (int d = 0; d < DIGITS; d++) begin
      bcd[4*d +: 4] = res_q[d].bcd;
      blank[d]      = res_q[d].blank;
      err[d]        = res_q[d].err;
    end
  end

  assign valid = valid_q;
  assign upd   = upd_q;

endmodule
